// File: rtl/inst_fetch_pkg.sv
// Shared constants and FSM encoding for the stage-1 instruction fetch unit.
package inst_fetch_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_2000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_MISS = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_hold_buf.sv
// One-entry skid register that parks a returned instruction while stage 2 is stalled.
module inst_fetch_hold_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_data,
  input  logic [31:0] d_pc,
  output logic [31:0] q_data,
  output logic [31:0] q_pc,
  output logic        q_valid
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_pc    <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_data  <= d_data;
      q_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Stage-1 fetch: issues I-cache reads for pc, presents {inst, pc, valid} to stage 2.
// Optional cycle counters (perf_fetched, perf_stall) are built when FETCH_PERF_CNT_EN is defined.
//
// state      | meaning
// FETCH_BOOT | first cycle after reset release, first read issued
// FETCH_RUN  | streaming, one read per cycle, returned data presented
// FETCH_MISS | I-cache stalled, address held, nothing presented
// FETCH_HOLD | stage 2 stalled, instruction parked in the hold buffer, no reads
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET_VAL = PC_RESET,
  parameter logic [31:0] NOP_INSTR    = INSTR_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] icache_addr,
  output logic        icache_re,
  input  logic        icache_stall,
  input  logic [31:0] icache_dout,
  input  logic        redirect,
  input  logic        hazard_stall,
  output logic        fetch_stall,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  fetch_state_t state;
  logic         req_live;
  logic [31:0]  req_pc;
  logic [31:0]  hold_data;
  logic [31:0]  hold_pc;
  logic         hold_valid;
  logic         cur_valid;
  logic         present;
  logic         keep;
  logic         accept;
  logic         hold_load;
  logic         hold_clear;
  logic         miss_next;

  // The hold buffer is older than any returning read, so it always wins the output mux.
  assign cur_valid   = hold_valid | req_live;
  assign present     = cur_valid & ~redirect & (state != FETCH_MISS);
  assign keep        = present & hazard_stall;

  // No read is issued while an instruction is parked, so buffer and live return never coexist.
  assign icache_addr = pc;
  assign icache_re   = reset & (state != FETCH_HOLD) & ~hold_valid;
  assign accept      = icache_re & ~icache_stall;
  // A read accepted while stage 2 stalls is dropped; the PC stays so it is refetched later.
  assign fetch_stall = ~reset | (~redirect & (~accept | keep));

  assign inst_valid  = present;
  assign inst_out    = present ? (hold_valid ? hold_data : icache_dout) : NOP_INSTR;
  assign inst_pc     = hold_valid ? hold_pc : req_pc;

  assign hold_load   = keep & ~hold_valid;
  assign hold_clear  = redirect | (hold_valid & present & ~hazard_stall);
  assign miss_next   = icache_stall & (icache_re | (state == FETCH_MISS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH_BOOT;
      req_live <= 1'b0;
      req_pc   <= PC_RESET_VAL;
    end else begin
      req_live <= accept & ~redirect & ~keep;
      if (accept) begin
        req_pc <= pc;
      end
      if (redirect) begin
        state <= FETCH_RUN;
      end else if (miss_next) begin
        state <= FETCH_MISS;
      end else if (keep) begin
        state <= FETCH_HOLD;
      end else begin
        state <= FETCH_RUN;
      end
    end
  end

  inst_fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .reset   (reset),
    .load    (hold_load),
    .clear   (hold_clear),
    .d_data  (icache_dout),
    .d_pc    (req_pc),
    .q_data  (hold_data),
    .q_pc    (hold_pc),
    .q_valid (hold_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (inst_valid) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (fetch_stall && (state != FETCH_BOOT)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized run against a program-order model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic        icache_stall = 1'b0;
  logic [31:0] icache_dout;
  logic        redirect = 1'b0;
  logic        hazard_stall = 1'b0;
  logic        fetch_stall;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic [31:0] redir_tgt = 32'h3000;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  inst_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .icache_addr  (icache_addr),
    .icache_re    (icache_re),
    .icache_stall (icache_stall),
    .icache_dout  (icache_dout),
    .redirect     (redirect),
    .hazard_stall (hazard_stall),
    .fetch_stall  (fetch_stall),
    .inst_out     (inst_out),
    .inst_pc      (inst_pc),
    .inst_valid   (inst_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Environment: PC register fed back by fetch_stall/redirect, and a one-cycle-latency I-cache.
  always @(posedge clk or negedge reset) begin
    if (!reset)            pc <= 32'h2000;
    else if (redirect)     pc <= redir_tgt;
    else if (!fetch_stall) pc <= pc + 32'd4;
  end

  always @(posedge clk) begin
    icache_dout <= (icache_re && !icache_stall) ? imem(icache_addr) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic h, input logic r, input logic s, input logic [31:0] tgt = 32'h3000);
    @(posedge clk);
    #1;
    hazard_stall = h;
    redirect     = r;
    icache_stall = s;
    redir_tgt    = tgt;
    #2;
  endtask

  task automatic boot();
    @(posedge clk);
    #1;
    reset = 1'b0;
    hazard_stall = 1'b0;
    redirect = 1'b0;
    icache_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_out"},   inst_out, 32'h0000_0013);
    chk({tag, "_pc"},    inst_pc, 32'h0000_2000);
    chk({tag, "_fstall"}, 32'(fetch_stall), 32'd1);
    chk({tag, "_re"},    32'(icache_re), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_perf_stall"}, perf_stall, 32'd0);
    chk({tag, "_perf_fetched"}, perf_fetched, 32'd0);
`endif
  endtask

  task automatic expect_inst(input string tag, input logic [31:0] p);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
    chk({tag, "_pc"},    inst_pc, p);
    chk({tag, "_out"},   inst_out, imem(p));
  endtask

  task automatic expect_bubble(input string tag);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_out"},   inst_out, 32'h0000_0013);
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic        h, r, s;
    int          delivered;

    repeat (2) @(posedge clk);
    #3;
    check_reset("reset");

    // Boot and straight-line streaming
    boot();
    chk("boot_valid", 32'(inst_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      expect_inst("stream", 32'h2000 + 32'(k * 4));
    end

    // I-cache miss on 0x2004
    boot();
    cyc(1'b0, 1'b0, 1'b1);
    expect_inst("miss_prev", 32'h2000);
    chk("miss_fstall0", 32'(fetch_stall), 32'd1);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b0, 1'b1);
      expect_bubble("miss");
      chk("miss_fstall", 32'(fetch_stall), 32'd1);
      chk("miss_addr", icache_addr, 32'h2004);
    end
    cyc(1'b0, 1'b0, 1'b0);
    expect_bubble("miss_exit");
    chk("miss_exit_addr", icache_addr, 32'h2004);
    cyc(1'b0, 1'b0, 1'b0);
    expect_inst("miss_deliver", 32'h2004);

    // Hazard hold on 0x2008, then redirect killing 0x2010
    boot();
    cyc(1'b0, 1'b0, 1'b0);
    expect_inst("h_a", 32'h2000);
    cyc(1'b0, 1'b0, 1'b0);
    expect_inst("h_b", 32'h2004);
    cyc(1'b1, 1'b0, 1'b0);
    expect_inst("hold1", 32'h2008);
    chk("hold1_fstall", 32'(fetch_stall), 32'd1);
    cyc(1'b1, 1'b0, 1'b0);
    expect_inst("hold2", 32'h2008);
    chk("hold2_re", 32'(icache_re), 32'd0);
    chk("hold2_fstall", 32'(fetch_stall), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    expect_inst("hold_rel", 32'h2008);
    chk("hold_rel_re", 32'(icache_re), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("refetch_valid", 32'(inst_valid), 32'd0);
    chk("refetch_addr", icache_addr, 32'h200C);
    cyc(1'b0, 1'b0, 1'b0);
    expect_inst("after_hold", 32'h200C);
    cyc(1'b0, 1'b1, 1'b0, 32'h3000);
    expect_bubble("redir_kill");
    cyc(1'b0, 1'b0, 1'b0);
    chk("redir_gap_valid", 32'(inst_valid), 32'd0);
    chk("redir_addr", icache_addr, 32'h3000);
    cyc(1'b0, 1'b0, 1'b0);
    expect_inst("redir_tgt", 32'h3000);

    // Reset asserted in MISS with a read about to be accepted
    boot();
    cyc(1'b0, 1'b0, 1'b1);
    expect_inst("rmiss_prev", 32'h2000);
    cyc(1'b0, 1'b0, 1'b1);
    expect_bubble("rmiss");
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check_reset("rmiss_rst");
    @(posedge clk);
    #3;
    chk("rmiss_stale_valid", 32'(inst_valid), 32'd0);
    chk("rmiss_stale_out", inst_out, 32'h0000_0013);

    // Randomized run against program-order model
    boot();
    exp_pc = 32'h2000;
    delivered = 0;
    for (int i = 0; i < 620; i++) begin
      h = 1'b0; r = 1'b0; s = 1'b0; tgt = 32'h3000;
      if (i < 600) begin
        h = ($urandom_range(0, 3) == 0);
        s = ($urandom_range(0, 4) == 0);
        r = ($urandom_range(0, 15) == 0);
        tgt = 32'h8000 + 32'($urandom_range(0, 255)) * 32'd4;
      end
      cyc(h, r, s, tgt);
      if (r) begin
        chk("rnd_kill", 32'(inst_valid), 32'd0);
        exp_pc = tgt;
      end else if (inst_valid) begin
        chk("rnd_pc", inst_pc, exp_pc);
        chk("rnd_out", inst_out, imem(exp_pc));
        if (!h) begin
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end
      end
    end
    chk("rnd_progress", 32'(delivered >= 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
